// File: rtl/uart_pkg.sv
// UART shared package: receiver/transmitter state encoding and
// frame helpers (frame length, parity bit) used by both directions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  // Total bit periods in one frame: start + data + parity + stops.
  function automatic int frame_bits(
    input int dw,
    input bit par,
    input bit two_stop
  );
    return 1 + dw + int'(par) + (two_stop ? 2 : 1);
  endfunction

  // Parity bit for up to 32 data bits (zero-extend narrower words).
  function automatic logic parity_bit(
    input logic [31:0] d,
    input logic        odd
  );
    return odd ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Ports: i_clk, i_reset_n (sync, active-low), i_d (async), o_q.
module sync_2ff #(
  parameter logic P_RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_s1 <= P_RESET_VAL;
      r_s2 <= P_RESET_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: sync, start detect, mid-bit sampling, parity/stop
// checks. Ports: i_clk, i_reset_n, i_rx -> ov_data, o_valid,
// o_parity_err, o_frame_err, o_busy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_PARITY      = 1,
  parameter int P_PARITY_ODD  = 0,
  parameter int P_2_STOP_BITS = 1,
  parameter int P_PERIOD      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_rx,
  output logic [P_DATA_WIDTH-1:0] ov_data,
  output logic                    o_valid,
  output logic                    o_parity_err,
  output logic                    o_frame_err,
  output logic                    o_busy
);

  localparam int LP_CW = $clog2(P_PERIOD);
  localparam int LP_BW = $clog2(P_DATA_WIDTH + 1);

  localparam logic [LP_CW-1:0] LP_HALF =
    LP_CW'(P_PERIOD / 2 - 1);
  localparam logic [LP_CW-1:0] LP_FULL =
    LP_CW'(P_PERIOD - 1);
  localparam logic [LP_BW-1:0] LP_LAST_DATA =
    LP_BW'(P_DATA_WIDTH - 1);
  localparam logic [LP_BW-1:0] LP_LAST_STOP =
    LP_BW'(P_2_STOP_BITS != 0 ? 1 : 0);
  localparam logic LP_ODD = (P_PARITY_ODD != 0);

  logic w_rx;

  uart_state_t r_state;
  uart_state_t w_state_next;

  logic [LP_CW-1:0]        r_cnt;
  logic [LP_CW-1:0]        w_cnt_next;
  logic [LP_BW-1:0]        r_bit;
  logic [LP_BW-1:0]        w_bit_next;
  logic [P_DATA_WIDTH-1:0] r_shift;
  logic [P_DATA_WIDTH-1:0] w_shift_next;
  logic [P_DATA_WIDTH-1:0] w_shift_in;
  logic                    r_perr_flag;
  logic                    w_perr_flag_next;
  logic                    r_ferr_flag;
  logic                    w_ferr_flag_next;
  logic                    w_ferr_now;
  logic                    w_tick;

  logic [P_DATA_WIDTH-1:0] r_data;
  logic [P_DATA_WIDTH-1:0] w_data_next;
  logic                    r_valid;
  logic                    w_valid_next;
  logic                    r_perr;
  logic                    w_perr_next;
  logic                    r_ferr;
  logic                    w_ferr_next;

  sync_2ff #(
    .P_RESET_VAL (1'b1)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_rx),
    .o_q       (w_rx)
  );

  // LSB-first line: each new bit enters at the MSB and moves right.
  generate
    if (P_DATA_WIDTH == 1) begin : g_one
      assign w_shift_in = w_rx;
    end else begin : g_many
      assign w_shift_in = {w_rx, r_shift[P_DATA_WIDTH-1:1]};
    end
  endgenerate

  assign w_tick     = (r_cnt == '0);
  assign w_ferr_now = r_ferr_flag | ~w_rx;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = w_tick ? r_cnt : r_cnt - LP_CW'(1);
    w_bit_next       = r_bit;
    w_shift_next     = r_shift;
    w_perr_flag_next = r_perr_flag;
    w_ferr_flag_next = r_ferr_flag;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_perr_next      = r_perr;
    w_ferr_next      = r_ferr;

    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_cnt_next       = LP_HALF;
          w_bit_next       = '0;
          w_perr_flag_next = 1'b0;
          w_ferr_flag_next = 1'b0;
          w_state_next     = START;
        end
      end

      START: begin
        if (w_tick) begin
          if (w_rx) begin
            w_state_next = IDLE;
          end else begin
            w_cnt_next   = LP_FULL;
            w_state_next = DATA;
          end
        end
      end

      DATA: begin
        if (w_tick) begin
          w_shift_next = w_shift_in;
          w_cnt_next   = LP_FULL;
          if (r_bit == LP_LAST_DATA) begin
            w_bit_next   = '0;
            w_state_next = (P_PARITY != 0) ? PARITY : STOP;
          end else begin
            w_bit_next = r_bit + LP_BW'(1);
          end
        end
      end

      PARITY: begin
        if (w_tick) begin
          w_cnt_next   = LP_FULL;
          w_bit_next   = '0;
          w_state_next = STOP;
          if (w_rx != parity_bit(32'(r_shift), LP_ODD)) begin
            w_perr_flag_next = 1'b1;
          end
        end
      end

      STOP: begin
        if (w_tick) begin
          if (r_bit == LP_LAST_STOP) begin
            w_valid_next = 1'b1;
            w_data_next  = r_shift;
            w_perr_next  = r_perr_flag;
            w_ferr_next  = w_ferr_now;
            // A low stop may be the start of a break; wait it out.
            w_state_next = w_ferr_now ? WAIT_HIGH : IDLE;
          end else begin
            w_ferr_flag_next = w_ferr_now;
            w_bit_next       = r_bit + LP_BW'(1);
            w_cnt_next       = LP_FULL;
          end
        end
      end

      WAIT_HIGH: begin
        if (w_rx) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_perr_flag <= 1'b0;
      r_ferr_flag <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit       <= w_bit_next;
      r_shift     <= w_shift_next;
      r_perr_flag <= w_perr_flag_next;
      r_ferr_flag <= w_ferr_flag_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_perr      <= w_perr_next;
      r_ferr      <= w_ferr_next;
    end
  end

  assign ov_data      = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: default config (8E2, P=16)
// plus a minimal config (1N1, P=4), against a frame-level model.
module tb_uart_rx;

  localparam int PA = 16;
  localparam int PB = 4;
  // Valid appears: 2 sync + half bit + remaining bits + 1 reg.
  localparam int LAT_A = 2 + PA / 2 + (12 - 1) * PA + 1;
  localparam int LAT_B = 2 + PB / 2 + (3 - 1) * PB + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         t0;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] data_a;
  logic       valid_a;
  logic       perr_a;
  logic       ferr_a;
  logic       busy_a;
  logic [0:0] data_b;
  logic       valid_b;
  logic       perr_b;
  logic       ferr_b;
  logic       busy_b;

  int   cyc;
  int   n_chk;
  int   n_pass;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
  int   vt_b[$];
  logic prev_a;
  logic prev_b;

  uart_rx dut_a (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rx         (rx_a),
    .ov_data      (data_a),
    .o_valid      (valid_a),
    .o_parity_err (perr_a),
    .o_frame_err  (ferr_a),
    .o_busy       (busy_a)
  );

  uart_rx #(
    .P_DATA_WIDTH  (1),
    .P_PARITY      (0),
    .P_PARITY_ODD  (0),
    .P_2_STOP_BITS (0),
    .P_PERIOD      (PB)
  ) dut_b (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rx         (rx_b),
    .ov_data      (data_b),
    .o_valid      (valid_b),
    .o_parity_err (perr_b),
    .o_frame_err  (ferr_b),
    .o_busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_a(input logic b);
    rx_a = b;
    repeat (PA) @(negedge clk);
  endtask

  task automatic bit_b(input logic b);
    rx_b = b;
    repeat (PB) @(negedge clk);
  endtask

  // 8 data bits LSB first, even parity, two stop bits.
  task automatic send_a(
    input logic [7:0] d,
    input logic       bad_par,
    input logic       bad_s0,
    input logic       bad_s1
  );
    exp_t e;
    logic pb;
    pb     = logic'($countones(d) % 2) ^ bad_par;
    e.data = d;
    e.perr = (($countones(d) + int'(pb)) % 2) != 0;
    e.ferr = bad_s0 | bad_s1;
    e.t0   = cyc;
    q_a.push_back(e);
    bit_a(1'b0);
    for (int i = 0; i < 8; i++) bit_a(d[i]);
    bit_a(pb);
    bit_a(~bad_s0);
    bit_a(~bad_s1);
  endtask

  task automatic send_b(input logic d);
    exp_t e;
    e.data = {7'd0, d};
    e.perr = 1'b0;
    e.ferr = 1'b0;
    e.t0   = cyc;
    q_b.push_back(e);
    bit_b(1'b0);
    bit_b(d);
    bit_b(1'b1);
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      chk("gap_a", 32'(prev_a), 32'd0);
      if (q_a.size() == 0) begin
        chk("spurious_a", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        chk("data_a", 32'(data_a), 32'(e_a.data));
        chk("perr_a", 32'(perr_a), 32'(e_a.perr));
        chk("ferr_a", 32'(ferr_a), 32'(e_a.ferr));
        chk("lat_a", 32'(cyc - e_a.t0), 32'(LAT_A));
      end
    end
    prev_a = valid_a;
  end

  always @(negedge clk) begin
    if (valid_b) begin
      chk("gap_b", 32'(prev_b), 32'd0);
      vt_b.push_back(cyc);
      if (q_b.size() == 0) begin
        chk("spurious_b", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        chk("data_b", 32'(data_b), 32'(e_b.data));
        chk("perr_b", 32'(perr_b), 32'd0);
        chk("ferr_b", 32'(ferr_b), 32'd0);
        chk("lat_b", 32'(cyc - e_b.t0), 32'(LAT_B));
      end
    end
    prev_b = valid_b;
  end

  initial begin
    logic [7:0] d;
    logic       bp;
    logic       bs;
    n_chk  = 0;
    n_pass = 0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    rx_a   = 1'b1;
    rx_b   = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_perr", 32'(perr_a), 32'd0);
    chk("rst_ferr", 32'(ferr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    repeat (PA) @(negedge clk);

    // Back-to-back clean frames.
    send_a(8'hA5, 1'b0, 1'b0, 1'b0);
    send_a(8'h3C, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1);

    // Parity bit forced to 1 on 0xA5.
    send_a(8'hA5, 1'b1, 1'b0, 1'b0);
    bit_a(1'b1);

    // Random frames, some with bad parity or a bad stop bit.
    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      send_a(d, bp, bs, 1'b0);
      if (bs) bit_a(1'b1);
    end
    bit_a(1'b1);

    // Bad first stop, then break held low.
    send_a(8'h55, 1'b0, 1'b1, 1'b1);
    rx_a = 1'b0;
    repeat (5 * PA) @(negedge clk);
    chk("break_busy", 32'(busy_a), 32'd1);
    bit_a(1'b1);
    chk("break_idle", 32'(busy_a), 32'd0);
    send_a(8'h0F, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1);

    // Glitch shorter than half a bit.
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("fs_busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    rx_a = 1'b1;
    repeat (PA / 2 + 3 - 4) @(negedge clk);
    chk("fs_idle", 32'(busy_a), 32'd0);
    bit_a(1'b1);
    send_a(8'h81, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1);

    // Reset pulse during data bit 3 of 0xFF.
    bit_a(1'b0);
    rx_a = 1'b1;
    repeat (3 * PA + PA / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", 32'(data_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    rst_n = 1'b1;
    repeat (6 * PA) @(negedge clk);
    send_a(8'h12, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1);

    // Minimal config: back-to-back 1, 0, 1.
    vt_b.delete();
    send_b(1'b1);
    send_b(1'b0);
    send_b(1'b1);
    repeat (3 * PB) @(negedge clk);
    chk("b_count", 32'(vt_b.size()), 32'd3);
    if (vt_b.size() == 3) begin
      chk("b_gap0", 32'(vt_b[1] - vt_b[0]), 32'(3 * PB));
      chk("b_gap1", 32'(vt_b[2] - vt_b[1]), 32'(3 * PB));
    end
    for (int n = 0; n < 6; n++) begin
      send_b(1'($urandom));
    end

    repeat (4 * PA) @(negedge clk);
    chk("pending_a", 32'(q_a.size()), 32'd0);
    chk("pending_b", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter, with the same frame format and parameter set.
- Recovers frames from an asynchronous serial line: synchronize, detect start, sample mid-bit, check parity/stop, deliver a parallel word with a one-cycle valid pulse.
- Sits between the board RX pin and the consumer logic (command parser, FIFO). No back-pressure.

Parameters:
- P_DATA_WIDTH, 8, data bits per frame, LSB first; ≥1.
- P_PARITY, 1, 1 = parity bit present after data.
- P_PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored if P_PARITY=0.
- P_2_STOP_BITS, 1, 1 = two stop bits checked, 0 = one.
- P_PERIOD, 16, clocks per bit; even, ≥4.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_rx  in  1  asynchronous serial line, idle high.
- ov_data  out  P_DATA_WIDTH  last received word.
- o_valid  out  1  one-cycle pulse: ov_data and error flags updated.
- o_parity_err  out  1  parity mismatch on the last frame.
- o_frame_err  out  1  a stop bit was sampled low on the last frame.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_reset_n=0 at posedge):
  - state=IDLE; 2-FF synchronizer flops=1.
  - ov_data=0; o_valid=0; both error flags=0; o_busy=0.
  - Reset mid-frame aborts the frame silently; no o_valid is produced.
- Synchronizer: i_rx → s1 → s2. All decisions use s2, which adds 2 cycles of latency.
- Delay counter: width $clog2(P_PERIOD). HALF = P_PERIOD/2 - 1; FULL = P_PERIOD - 1.
- Bit counter: width $clog2(P_DATA_WIDTH+1).
- States:
  - IDLE: on s2=0, load HALF and go to START. Call this observation cycle t0.
  - START: count down. At 0, sample s2 (cycle t0 + P_PERIOD/2).
    - s2=1: false start, return to IDLE with no outputs.
    - s2=0: load FULL and go to DATA.
  - DATA: at each count 0, shift s2 into the MSB of a right-shift register and reload FULL.
    - Bit k (k = 0..DW-1) is sampled at t0 + P_PERIOD/2 + (k+1)*P_PERIOD.
    - After DW bits, go to PARITY if P_PARITY, else STOP.
  - PARITY: sample one bit.
    - Expected = ^data (even) or ~^data (odd).
    - Mismatch sets an internal error flag.
  - STOP: sample 1 or 2 bits; any 0 sets an internal frame flag. After the final stop sample:
    - Next cycle: o_valid=1; ov_data, o_parity_err and o_frame_err are loaded.
    - No frame error: go to IDLE in the same transition. The line is already high mid-stop, so the next start edge can be detected immediately and back-to-back frames are supported.
    - Frame error: go to WAIT_HIGH.
  - WAIT_HIGH: stay until s2=1, then go to IDLE. This prevents a break condition (line held low) from generating repeated frames.
- Output hold rules:
  - ov_data and both error flags hold until the next o_valid.
  - o_valid is never high for two consecutive cycles.
  - A frame with errors still asserts o_valid and delivers data; the consumer decides.
- Overrun: not detected. The consumer must capture on o_valid.
- Frame tolerance: mid-bit sampling tolerates about ±(P_PERIOD/2 - 1) clocks of accumulated drift per frame.

Decomposition:
- Shared package uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Frame-length function, computed from data width, parity and stop bits, shared with the transmitter.
  - Parity helper function, shared with the transmitter.
- Sub-module sync_2ff: two-flop synchronizer with reset value parameter (1 here). Reusable for other async inputs.
- FSM, counters and shift register live in uart_rx.

Test Plan:
1. Loopback: UartTx feeding uart_rx, same params (DW=8, even parity, 2 stops, P=16); send 0xA5 then 0x3C back-to-back.
   → Two o_valid pulses; ov_data = 0xA5 then 0x3C; both error flags 0.
   → Each pulse occurs exactly 2 + 8 + 11*16 + 1 cycles after the falling edge of i_rx.
2. Parity error: hand-drive frame 0xA5 with parity bit=1 (expected 0).
   → o_valid=1, ov_data=0xA5, o_parity_err=1, o_frame_err=0.
3. Frame error and break: drive 0x55 with first stop bit=0, then hold i_rx low for 5 bit periods.
   → One o_valid with o_frame_err=1; FSM stays in WAIT_HIGH with o_busy=1.
   → No further o_valid until the line returns high and a new valid frame (0x0F) is received cleanly.
4. False start: i_rx low for 4 clocks (P=16), then high.
   → o_busy pulses, no o_valid; back in IDLE within P/2+3 cycles; a following frame 0x81 is received correctly.
5. Reset mid-frame: assert i_reset_n=0 for 1 cycle during data bit 3 of 0xFF.
   → All outputs return to reset values and no o_valid fires.
   → A subsequent frame 0x12 (started after the line idles high for 1 bit period) is received correctly.
6. Parameter corners: DW=1, no parity, 1 stop, P=4; send bits 1, 0, 1.
   → ov_data = 1, 0, 1; o_valid pulses spaced by exactly 3*4 cycles when frames are back-to-back.
